u2_to_zm_seq: RTL and testbench
===============================

Name: u2_to_zm_seq

Overview:
- Sequential converter from two's complement (U2) to sign-magnitude (ZM). It is the reverse direction of the team's combinational ZM-to-U2 converter.
- Sits in the ALU datapath as a multi-cycle unit with a start/done handshake.
- Negates negative operands bit-serially (LSB first), one magnitude bit per clock, so latency is fixed regardless of value.
- Produces the same 4-bit status word layout as the other ALU units.

Parameters:
m, 4, operand/result width in bits (sign bit is bit m-1); legal m >= 2
n, 2, kept for interface uniformity with the other ALU modules; unused

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_start  input  1  request; sampled only in IDLE
i_argA  input  m  U2 operand; sampled on the accepting edge only
o_busy  output  1  high while a conversion is in progress (CONV or DONE)
o_done  output  1  one-cycle pulse: o_result/o_status valid and newly updated
o_result  output  m  ZM result; held until the next o_done
o_status  output  4  [0] zero, [1] negative, [2] even parity of o_result, [3] overflow

Behaviour:
- Reset (i_rst_n low, asynchronous): state IDLE; o_busy=0, o_done=0, o_result='0, o_status=4'b0000; internal operand/shift/counter registers cleared. Reset asserted mid-conversion aborts it; no o_done is produced.
- States: IDLE, CONV, DONE.
- IDLE:
  - if i_start=1 at a rising edge: latch i_argA into op, sign<=op[m-1], idx<=0, seen_one<=0 → CONV.
  - otherwise stay in IDLE.
- CONV: one bit per cycle, idx = 0..m-2.
  - sign=0: mag[idx]=op[idx].
  - sign=1: mag[idx]=op[idx] while seen_one=0; after that mag[idx]=~op[idx]. seen_one is set after processing a bit with op[idx]=1 (copy up to and including the first 1, invert the rest).
  - After idx=m-2 → DONE. CONV lasts exactly m-1 cycles.
- DONE, one cycle: o_done=1, o_result and o_status are registered, then → IDLE.
- Latency: o_done is high in the m-th cycle after the accepting edge (m=4: 4 cycles). Throughput is one conversion per m+1 cycles, because i_start is not sampled during DONE.
- Result:
  - non-overflow: o_result = {sign, mag[m-2:0]}.
  - overflow (op = 1 followed by m-1 zeros, i.e. the U2 minimum, which has no ZM representation): o_result='0 and o_status=4'b1000; all other flags are 0.
- Status (non-overflow):
  - [0] = (o_result == '0)
  - [1] = o_result[m-1]
  - [2] = count of ones in o_result is even (an all-zero result counts as even)
  - [3] = 0
- i_start during CONV/DONE is ignored and not queued. i_argA changes after acceptance have no effect.
- o_result/o_status change only in the DONE cycle; they are stable otherwise, including across ignored starts.
- Single always_ff for the state/datapath registers, reset branch on negedge i_rst_n. No latches; every combinational signal is assigned on every path.

Test Plan:
- m=4, i_argA=0101, i_start pulse: o_busy rises next cycle; o_done is high 4 cycles after the accepting edge; o_result=0101, o_status=0100.
- i_argA=1101 (-3) → o_result=1011, o_status=0010. i_argA=1111 (-1) → o_result=1001, o_status=0110.
- i_argA=0000 → o_result=0000, o_status=0101. i_argA=1000 (U2 min) → o_result=0000, o_status=1000.
- Back-to-back:
  - Convert 0011, then pulse i_start=1 with i_argA=1110 during CONV: it is ignored, no second o_done, and o_result stays 0011 (status 0100).
  - A new start in IDLE after DONE converts 1110 → 1010, status 0110.
- Reset mid-op: assert i_rst_n=0 during the second CONV cycle. All outputs go to 0 immediately (asynchronously); no o_done follows. After release, a fresh 0111 converts to 0111, status 0000.
- Exhaustive m=4 sweep of all 16 inputs against a reference model (result, status, latency exactly 4); repeat the 1000..0 overflow and -1 cases at m=8.

Source files
------------

// File: rtl/u2_to_zm_seq.sv
// Bit-serial two's-complement to sign-magnitude converter with a start/done handshake.
// Magnitude bits are produced LSB first, one per clock; the U2 minimum is flagged as overflow.
module u2_to_zm_seq #(
  parameter int m = 4,
  parameter int n = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [m-1:0] i_argA,
  output logic         o_busy,
  output logic         o_done,
  output logic [m-1:0] o_result,
  output logic [3:0]   o_status
);

  localparam int unsigned IW = $clog2(m);
  localparam logic [IW-1:0] LAST = IW'(m - 2);

  if (m < 2 || n < 0) begin : g_param_check
    $error("u2_to_zm_seq: m must be >= 2 and n non-negative");
  end

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state, state_nxt;
  logic [m-1:0]    op;
  logic            sign;
  logic            seen_one;
  logic [IW-1:0]   idx;
  logic [m-2:0]    mag, mag_nxt;
  logic            bit_out;
  logic            ovf;
  logic [m-1:0]    res_nxt;
  logic [3:0]      st_nxt;

  // op shifts right each CONV cycle, so op[0] is always the bit being processed
  always_comb begin
    bit_out        = op[0] ^ (sign & seen_one);
    mag_nxt        = mag >> 1;
    mag_nxt[m-2]   = bit_out;
    // A negative operand that never shows a 1 below the sign bit is the U2 minimum
    ovf            = sign & ~(seen_one | op[0]);
    res_nxt        = '0;
    st_nxt         = 4'b1000;
    if (!ovf) begin
      res_nxt      = {sign, mag_nxt};
      st_nxt       = {1'b0, ~^res_nxt, res_nxt[m-1], (res_nxt == '0)};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = CONV;
      CONV:    if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      op       <= '0;
      sign     <= 1'b0;
      seen_one <= 1'b0;
      idx      <= '0;
      mag      <= '0;
      o_result <= '0;
      o_status <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (i_start) begin
            op       <= i_argA;
            sign     <= i_argA[m-1];
            seen_one <= 1'b0;
            idx      <= '0;
            mag      <= '0;
          end
        end
        CONV: begin
          op       <= op >> 1;
          mag      <= mag_nxt;
          seen_one <= seen_one | op[0];
          idx      <= idx + 1'b1;
          if (idx == LAST) begin
            o_result <= res_nxt;
            o_status <= st_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (state)
      CONV: o_busy = 1'b1;
      DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_u2_to_zm_seq.sv
// Self-checking bench for u2_to_zm_seq at m=4 and m=8 against an arithmetic reference model.
module tb_u2_to_zm_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s4, s8;
  logic [3:0] a4;
  logic [7:0] a8;
  logic       busy4, done4, busy8, done8;
  logic [3:0] res4, st4, st8;
  logic [7:0] res8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  u2_to_zm_seq #(.m(4), .n(2)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s4), .i_argA(a4),
    .o_busy(busy4), .o_done(done4), .o_result(res4), .o_status(st4)
  );

  u2_to_zm_seq #(.m(8), .n(2)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s8), .i_argA(a8),
    .o_busy(busy8), .o_done(done8), .o_result(res8), .o_status(st8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: interpret as signed integer, take absolute value, rebuild sign-magnitude
  function automatic void ref_conv(input int w, input int a, output logic [7:0] r, output logic [3:0] s);
    int sv, mg, half;
    half = 1 << (w - 1);
    sv = (a >= half) ? a - (1 << w) : a;
    if (sv == -half) begin
      r = '0;
      s = 4'b1000;
    end else begin
      mg = (sv < 0) ? -sv : sv;
      r = 8'((sv < 0) ? half + mg : mg);
      s = {1'b0, ($countones(r) % 2 == 0), (sv < 0), (r == 0)};
    end
  endfunction

  function automatic logic get_busy(input bit wide);
    return wide ? busy8 : busy4;
  endfunction
  function automatic logic get_done(input bit wide);
    return wide ? done8 : done4;
  endfunction
  function automatic logic [7:0] get_res(input bit wide);
    return wide ? res8 : {4'b0, res4};
  endfunction
  function automatic logic [3:0] get_st(input bit wide);
    return wide ? st8 : st4;
  endfunction

  task automatic run(input bit wide, input logic [7:0] a, input string tag);
    int lat;
    logic [7:0] er;
    logic [3:0] es;
    ref_conv(wide ? 8 : 4, int'(a), er, es);
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(get_busy(wide)), 32'd0);
    if (wide) begin s8 = 1'b1; a8 = a; end
    else begin s4 = 1'b1; a4 = a[3:0]; end
    @(posedge clk); #1;
    s4 = 1'b0; s8 = 1'b0;
    a4 = 4'($urandom); a8 = 8'($urandom);
    check({tag, "_busy"}, 32'(get_busy(wide)), 32'd1);
    lat = 1;
    while (!get_done(wide) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), wide ? 32'd8 : 32'd4);
    check({tag, "_res"}, 32'(get_res(wide)), 32'(er));
    check({tag, "_st"}, 32'(get_st(wide)), 32'(es));
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(get_done(wide)), 32'd0);
    check({tag, "_busy_end"}, 32'(get_busy(wide)), 32'd0);
  endtask

  initial begin
    int lat, extra;
    rst_n = 1'b0; s4 = 1'b0; s8 = 1'b0; a4 = '0; a8 = '0;
    #1;
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_res", 32'(res4), 32'd0);
    check("rst_st", 32'(st4), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(1'b0, 8'h05, "p0101");
    run(1'b0, 8'h0D, "n1101");
    run(1'b0, 8'h0F, "n1111");
    run(1'b0, 8'h00, "z0000");
    run(1'b0, 8'h08, "ovf4");

    // Start during CONV must be ignored and not queued
    @(negedge clk); s4 = 1'b1; a4 = 4'b0011;
    @(posedge clk); #1; s4 = 1'b0;
    @(negedge clk); s4 = 1'b1; a4 = 4'b1110;
    @(negedge clk); s4 = 1'b0;
    lat = 2;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat", 32'(lat), 32'd4);
    check("b2b_res", 32'(res4), 32'h3);
    check("b2b_st", 32'(st4), 32'h4);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done4) extra++;
    end
    check("b2b_nodone", 32'(extra), 32'd0);
    check("b2b_hold", 32'(res4), 32'h3);
    run(1'b0, 8'h0E, "b2b_1110");

    // Asynchronous reset in the second CONV cycle
    run(1'b0, 8'h05, "pre_rst");
    @(negedge clk); s4 = 1'b1; a4 = 4'b1101;
    @(posedge clk); #1; s4 = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy4), 32'd0);
    check("arst_done", 32'(done4), 32'd0);
    check("arst_res", 32'(res4), 32'd0);
    check("arst_st", 32'(st4), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done4 || busy4) extra++;
    end
    check("arst_quiet", 32'(extra), 32'd0);
    run(1'b0, 8'h07, "post_rst");

    for (int v = 0; v < 16; v++) run(1'b0, 8'(v), "sweep4");

    run(1'b1, 8'h80, "ovf8");
    run(1'b1, 8'hFF, "neg1_8");
    run(1'b1, 8'h7F, "max8");
    for (int i = 0; i < 12; i++) run(1'b1, 8'($urandom), "rand8");
    for (int i = 0; i < 8; i++) run(1'b0, 8'($urandom_range(0, 15)), "rand4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 1 expected 0");
    $fatal(1, "bench timeout");
  end

endmodule
